// File: rtl/lenet_fc2_layer_if.sv
// ============================================================================
// Module      : lenet_fc2_layer_if
// Description : Control, memory-read and buffer-C write bundle of the FC2 layer.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface lenet_fc2_layer_if #(
    parameter int W_AW = 14
);
    logic            start;
    logic            busy;
    logic            done;
    logic [6:0]      in_addr;
    logic [7:0]      in_data;
    logic [W_AW-1:0] w_addr;
    logic [7:0]      w_data;
    logic [6:0]      b_addr;
    logic [31:0]     b_data;
    logic            out_we;
    logic [6:0]      out_addr;
    logic [7:0]      out_data;

    modport master (
        input  start, in_data, w_data, b_data,
        output busy, done, in_addr, w_addr, b_addr, out_we, out_addr, out_data
    );

    modport slave (
        output start, in_data, w_data, b_data,
        input  busy, done, in_addr, w_addr, b_addr, out_we, out_addr, out_data
    );
endinterface

`default_nettype wire

// File: rtl/lenet_fc2_layer.sv
// ============================================================================
// Module      : lenet_fc2_layer
// Description : LeNet-5 FC2 (120->84) MAC layer with ReLU and int8 requantisation.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lenet_fc2_layer #(
    parameter int IN_LEN  = 120,
    parameter int OUT_LEN = 84,
    parameter int SHIFT   = 8,
    parameter int W_AW    = 14
) (
    input  wire logic               clk,
    input  wire logic               rst,
    lenet_fc2_layer_if.master       bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_BIAS_ADDR = 3'd1,
        S_BIAS_CAP  = 3'd2,
        S_MAC       = 3'd3,
        S_WRITE     = 3'd4,
        S_FINISH    = 3'd5
    } state_t;

    localparam logic [6:0]      c_IN_LAST  = 7'(IN_LEN - 1);
    localparam logic [6:0]      c_N_LAST   = 7'(OUT_LEN - 1);
    localparam logic [W_AW-1:0] c_IN_LEN_W = W_AW'(IN_LEN);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [6:0]             r_n;
    logic [6:0]             r_k;
    logic [W_AW-1:0]        r_base;
    logic [6:0]             r_in_addr;
    logic [W_AW-1:0]        r_w_addr;
    logic signed [31:0]     r_acc;
    logic [6:0]             r_out_addr;
    logic [7:0]             r_out_data;

    logic signed [15:0]     w_in_ext;
    logic signed [15:0]     w_wt_ext;
    logic signed [15:0]     w_prod;
    logic signed [31:0]     w_prod32;
    logic signed [31:0]     w_acc_sum;
    logic signed [31:0]     w_bias_sum;
    logic signed [31:0]     w_shifted;
    logic [7:0]             w_q;
    logic                   w_addr_adv;

    // int8 x int8 always fits in 16 bits, so the low half of a 16x16 product is exact
    assign w_in_ext   = {{8{bus.in_data[7]}}, bus.in_data};
    assign w_wt_ext   = {{8{bus.w_data[7]}}, bus.w_data};
    assign w_prod     = w_in_ext * w_wt_ext;
    assign w_prod32   = {{16{w_prod[15]}}, w_prod};
    assign w_acc_sum  = r_acc + w_prod32;
    assign w_bias_sum = $signed(bus.b_data) + w_prod32;
    assign w_shifted  = w_acc_sum >>> SHIFT;
    assign w_addr_adv = (r_in_addr != c_IN_LAST);

    always_comb begin
        w_q = 8'd0;
        if (w_shifted[31]) begin
            w_q = 8'd0;
        end else if (w_shifted > 32'sd127) begin
            w_q = 8'd127;
        end else begin
            w_q = w_shifted[7:0];
        end
    end

    always_comb begin
        w_state_next = r_state;
        bus.busy     = (r_state != S_IDLE);
        bus.done     = 1'b0;
        bus.out_we   = 1'b0;
        case (r_state)
            S_IDLE:      if (bus.start) w_state_next = S_BIAS_ADDR;
            S_BIAS_ADDR: w_state_next = S_BIAS_CAP;
            S_BIAS_CAP:  w_state_next = S_MAC;
            S_MAC:       if (r_k == c_IN_LAST) w_state_next = S_WRITE;
            S_WRITE: begin
                bus.out_we   = 1'b1;
                w_state_next = (r_n == c_N_LAST) ? S_FINISH : S_BIAS_ADDR;
            end
            S_FINISH: begin
                bus.done     = 1'b1;
                w_state_next = S_IDLE;
            end
            default:     w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_n        <= 7'd0;
            r_k        <= 7'd0;
            r_base     <= '0;
            r_in_addr  <= 7'd0;
            r_w_addr   <= '0;
            r_acc      <= 32'sd0;
            r_out_addr <= 7'd0;
            r_out_data <= 8'd0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_n       <= 7'd0;
                        r_base    <= '0;
                        r_in_addr <= 7'd0;
                        r_w_addr  <= '0;
                    end
                end
                S_BIAS_ADDR: begin
                    r_in_addr <= r_in_addr + 7'd1;
                    r_w_addr  <= r_w_addr + 1'b1;
                end
                S_BIAS_CAP: begin
                    r_acc <= w_bias_sum;
                    r_k   <= 7'd1;
                    if (w_addr_adv) begin
                        r_in_addr <= r_in_addr + 7'd1;
                        r_w_addr  <= r_w_addr + 1'b1;
                    end
                end
                S_MAC: begin
                    r_acc <= w_acc_sum;
                    if (w_addr_adv) begin
                        r_in_addr <= r_in_addr + 7'd1;
                        r_w_addr  <= r_w_addr + 1'b1;
                    end
                    // Result is registered here so out_data is stable for the whole WRITE cycle
                    if (r_k == c_IN_LAST) begin
                        r_out_addr <= r_n;
                        r_out_data <= w_q;
                    end else begin
                        r_k <= r_k + 7'd1;
                    end
                end
                S_WRITE: begin
                    if (r_n != c_N_LAST) begin
                        r_n       <= r_n + 7'd1;
                        r_base    <= r_base + c_IN_LEN_W;
                        r_in_addr <= 7'd0;
                        r_w_addr  <= r_base + c_IN_LEN_W;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_addr  = r_in_addr;
    assign bus.w_addr   = r_w_addr;
    assign bus.b_addr   = r_n;
    assign bus.out_addr = r_out_addr;
    assign bus.out_data = r_out_data;

endmodule

`default_nettype wire

// File: doc/lenet_fc2_layer.md
Name: lenet_fc2_layer

Overview:
Fully-connected FC2 stage of the LeNet-5 inference pipeline, 120 -> 84, with ReLU and int8 requantisation. It reads the FC1 activations buffer, the FC2 weight ROM and the FC2 bias ROM, all with synchronous 1-cycle read latency. It writes 84 int8 activations into buffer C, which the FC3 stage consumes directly. One start pulse processes one image.

Parameters:
IN_LEN, 120, input vector length (FC1 outputs)
OUT_LEN, 84, output neurons
SHIFT, 8, arithmetic right-shift applied to the int32 accumulator before ReLU/saturation
W_AW, 14, weight address width (must hold IN_LEN*OUT_LEN-1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  begin layer; sampled only in IDLE
busy  out  1  high while layer in progress
done  out  1  one-cycle pulse after last output written
in_addr  out  7  FC1 activation buffer read address
in_data  in  8  signed int8 activation, valid 1 cycle after in_addr
w_addr  out  W_AW  weight ROM address, row-major: neuron*IN_LEN + input
w_data  in  8  signed int8 weight, valid 1 cycle after w_addr
b_addr  out  7  bias ROM address (neuron index)
b_data  in  32  signed int32 pre-scaled bias, valid 1 cycle after b_addr
out_we  out  1  buffer C write strobe
out_addr  out  7  buffer C write address (neuron index)
out_data  out  8  int8 activation, range 0..127

Behaviour:
- Reset: state IDLE; busy, done and out_we are 0; all address outputs, out_data, accumulator and counters are 0.
- FSM states: IDLE, BIAS_ADDR, BIAS_CAP, MAC, WRITE, FINISH.
- IDLE: start=1 -> BIAS_ADDR with neuron n=0 and weight base=0; busy goes 1 on the same edge.
- BIAS_ADDR (1 cycle): drive b_addr=n, in_addr=0, w_addr=base.
- BIAS_CAP (1 cycle): acc <= b_data + in_data*w_data (element 0). Drive in_addr=1 and w_addr=base+1.
- MAC (IN_LEN-1 cycles): acc += in_data*w_data for element k = 1..IN_LEN-1. Issue address k+1 each cycle while k+1 < IN_LEN. After element IN_LEN-1 -> WRITE.
- WRITE (1 cycle): out_we=1, out_addr=n, out_data=requant(acc).
  - If n==OUT_LEN-1 -> FINISH.
  - Otherwise n++, base += IN_LEN, -> BIAS_ADDR.
- FINISH (1 cycle): done=1, busy=0 on exit, -> IDLE.
- Weight address is generated incrementally (running base plus offset). No multiplier is used for addressing.
- Arithmetic:
  - Each product is the 16-bit signed product of two int8 values, sign-extended to 32 bits.
  - acc is 32-bit signed and wraps modulo 2^32. There is no accumulator saturation.
- requant(acc): s = acc >>> SHIFT (arithmetic shift, floor toward -inf). Then ReLU: s<0 -> 0. Then saturate: s>127 -> 127. out_data = s[7:0].
- Timing:
  - Start accepted at edge T0.
  - Neuron n write occurs in the cycle starting at T0 + 1 + n*(IN_LEN+2) + (IN_LEN+1).
  - Writes are spaced IN_LEN+2 cycles apart.
  - done pulses in the cycle after the last write. Defaults: last write at T0+10248, done at T0+10249.
- out_we is high only in WRITE. out_addr and out_data hold their last values otherwise.
- start while busy: ignored, with no restart and no effect on the current run.
- start asserted in the FINISH cycle: ignored. start is accepted only from IDLE on a later cycle.
- rst mid-operation: return to reset state on the next edge. No further writes; done is not pulsed.
- Back-to-back runs: a second start in the first IDLE cycle after done runs again with identical timing.

Test Plan:
- Reset/idle: hold rst 5 cycles, then release with start=0 for 20 cycles -> busy=0, done=0 and out_we=0 throughout; all outputs 0.
- Unity sum, SHIFT=0: all in=1, all w=1, all bias=0 -> 84 writes, each out_data=120 at addresses 0..83. First write at T0+122, done at T0+10249.
- Saturation and ReLU, SHIFT=8:
  - in=127, w=127, bias=0 -> acc=1935480 -> 7560 -> out 127 for all neurons.
  - Same with w=-1 on neuron 5 -> out 0 at address 5.
- Floor shift, SHIFT=8, weights 0:
  - bias 255 -> 0; bias 256 -> 1; bias 32767 -> 127; bias -1 -> 0.
- Control hazards:
  - start pulsed at T0+500 mid-run -> timing unchanged, exactly 84 writes.
  - rst at T0+3000 -> no writes after reset, busy=0, no done pulse. A new start afterwards completes normally.
- Golden: load FC1 output, FC2 weights/biases and the golden FC2 output files. Run one image -> all 84 buffer C bytes match exactly, with 0 mismatches reported.
